synapse_receiver: RTL and testbench

Receiving end of the neuron spike link: samples the held `synout` impulses of K presynaptic neurons, accepts exactly one spike per impulse, and converts accepted spikes into a signed Q16.16 synaptic current `I`. The current decays exponentially by a configurable shift and drives the `I` input of the postsynaptic `neuron`. It replaces the hand-driven `I` stimulus in current neuron benches.

---
 rtl/synapse_receiver_if.sv | 39 +++
 rtl/synapse_receiver.sv | 189 ++++++++++++++++++
 tb/tb_synapse_receiver.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/synapse_receiver_if.sv
// -----------------------------------------------------------------------------
// synapse_receiver_if
//
// Bundles the spike link and current output of one synapse_receiver.
//
//   synin      [K]   impulse lines, one per presynaptic neuron (their synout)
//   weight     [K*N] per-input signed Q16.16 weight, input k at [k*N +: N]
//   I          [N]   signed Q16.16 synaptic current (registered)
//   spike_seen [K]   one-cycle pulse per accepted spike (registered)
//
// Modports:
//   master : the side that drives impulses and weights and consumes I
//   slave  : the synapse_receiver itself
// -----------------------------------------------------------------------------
interface synapse_receiver_if #(
  parameter int N = 32,
  parameter int K = 2
);

  logic [K-1:0]   synin;
  logic [K*N-1:0] weight;
  logic [N-1:0]   I;
  logic [K-1:0]   spike_seen;

  modport master (
    output synin,
    output weight,
    input  I,
    input  spike_seen
  );

  modport slave (
    input  synin,
    input  weight,
    output I,
    output spike_seen
  );

endinterface

// File: rtl/synapse_receiver.sv
// -----------------------------------------------------------------------------
// synapse_receiver
//
// Receiving end of the neuron spike link. Samples the held synout impulses of
// K presynaptic neurons, accepts exactly one spike per impulse and turns the
// accepted spikes into a signed Q16.16 synaptic current I that decays
// exponentially. I is registered and can drive neuron.I directly.
//
// Parameters:
//   N            datapath width (Q16.16 when N = 32)
//   K            number of presynaptic inputs
//   DECAY_SHIFT  decay step is |I| >> DECAY_SHIFT, rounded toward zero
//   DECAY_PERIOD clocks between decay events (>= 1)
//   MIN_WIDTH    minimum impulse length in cycles (glitch filter only)
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    synapse_receiver_if.slave: synin, weight in; I, spike_seen out
//
// Configuration macro:
//   SYNAPSE_GLITCH_FILTER_EN  when defined, an impulse is accepted only once it
//                             has been high for MIN_WIDTH consecutive samples;
//                             otherwise every rising edge is accepted.
// -----------------------------------------------------------------------------
module synapse_receiver #(
  parameter int N            = 32,
  parameter int K            = 2,
  parameter int DECAY_SHIFT  = 4,
  parameter int DECAY_PERIOD = 4,
  parameter int MIN_WIDTH    = 3
) (
  input  logic              clk,
  input  logic              reset,
  synapse_receiver_if.slave bus
);

  // Intermediate sum: current plus up to K weights minus a decay step.
  localparam int SW = N + $clog2(K) + 2;

  localparam int CW = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DECAY_PERIOD - 1);

  // Saturation bounds of an N-bit signed value, sign-extended to SW bits.
  localparam logic signed [SW-1:0] I_MAX = {{(SW-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [SW-1:0] I_MIN = {{(SW-N+1){1'b1}}, {(N-1){1'b0}}};

  if (DECAY_PERIOD < 1 || MIN_WIDTH < 1 || K < 1) begin : g_bad_cfg
    $error("synapse_receiver: DECAY_PERIOD, MIN_WIDTH and K must be >= 1");
  end

  // ---------------------------------------------------------------------------
  // Decay timebase
  // ---------------------------------------------------------------------------
  logic [CW-1:0] decay_cnt;
  logic          decay_evt;

  assign decay_evt = (decay_cnt == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      decay_cnt <= '0;
    end else if (decay_evt) begin
      decay_cnt <= '0;
    end else begin
      decay_cnt <= decay_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Spike acceptance: one accept per impulse, regardless of hold time
  // ---------------------------------------------------------------------------
  logic [K-1:0] accept;

`ifdef SYNAPSE_GLITCH_FILTER_EN

  localparam int RW = $clog2(MIN_WIDTH + 1);
  localparam logic [RW-1:0] RUN_FULL = RW'(MIN_WIDTH);
  localparam logic [RW-1:0] RUN_ARM  = RW'(MIN_WIDTH - 1);

  // Saturating high-run counters. Resetting them to full means a line that is
  // already high when reset releases looks like an old impulse and is ignored
  // until it drops.
  logic [RW-1:0] run_cnt [K];

  always_ff @(posedge clk) begin
    for (int k = 0; k < K; k++) begin
      if (reset) begin
        run_cnt[k] <= RUN_FULL;
      end else if (!bus.synin[k]) begin
        run_cnt[k] <= '0;
      end else if (run_cnt[k] != RUN_FULL) begin
        run_cnt[k] <= run_cnt[k] + 1'b1;
      end
    end
  end

  // Accept on the sample that moves the run from MIN_WIDTH-1 to MIN_WIDTH.
  for (genvar k = 0; k < K; k++) begin : g_accept
    assign accept[k] = bus.synin[k] && (run_cnt[k] == RUN_ARM);
  end

`else

  // Previous sample of each line. Resetting to ones masks an impulse that is
  // held across reset: no rising edge is seen until the line returns low.
  logic [K-1:0] synin_prev;

  // NOTE: reset is synchronous here: it is sampled like any other input inside
  // the clocked block, so there is no asynchronous path into the flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      synin_prev <= '1;
    end else begin
      synin_prev <= bus.synin;
    end
  end

  assign accept = bus.synin & ~synin_prev;

`endif

  // ---------------------------------------------------------------------------
  // Current update: I_next = sat(I - decay + sum of accepted weights)
  // ---------------------------------------------------------------------------
  logic        [N-1:0]  i_q;
  logic        [K-1:0]  seen_q;
  logic signed [SW-1:0] w_ext [K];
  logic signed [SW-1:0] i_ext;
  logic signed [SW-1:0] i_mag;
  logic signed [SW-1:0] decay_mag;
  logic signed [SW-1:0] decay_d;
  logic signed [SW-1:0] weight_sum;
  logic signed [SW-1:0] i_sum;
  logic        [N-1:0]  i_sat;

  for (genvar k = 0; k < K; k++) begin : g_wext
    assign w_ext[k] = {{(SW-N){bus.weight[k*N+N-1]}}, bus.weight[k*N +: N]};
  end

  // NOTE: every variable of this combinational block receives a value before
  // any conditional update, so no path can leave it holding (no latch).
  always_comb begin
    i_ext = {{(SW-N){i_q[N-1]}}, i_q};

    // Decay on the magnitude so both signs round toward zero; the wide sum
    // keeps -I representable even for the most negative current.
    i_mag     = i_q[N-1] ? -i_ext : i_ext;
    decay_mag = i_mag >>> DECAY_SHIFT;
    // Once the shift underflows, step by one LSB so the residue reaches 0.
    if (decay_mag == '0 && i_ext != '0) begin
      decay_mag = SW'(1);
    end
    decay_d = i_q[N-1] ? -decay_mag : decay_mag;

    weight_sum = '0;
    for (int k = 0; k < K; k++) begin
      if (accept[k]) begin
        weight_sum = weight_sum + w_ext[k];
      end
    end

    i_sum = i_ext - (decay_evt ? decay_d : '0) + weight_sum;

    if (i_sum > I_MAX) begin
      i_sat = {1'b0, {(N-1){1'b1}}};
    end else if (i_sum < I_MIN) begin
      i_sat = {1'b1, {(N-1){1'b0}}};
    end else begin
      i_sat = i_sum[N-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      i_q    <= '0;
      seen_q <= '0;
    end else begin
      i_q    <= i_sat;
      seen_q <= accept;
    end
  end

  assign bus.I          = i_q;
  assign bus.spike_seen = seen_q;

endmodule

// File: tb/tb_synapse_receiver.sv
// -----------------------------------------------------------------------------
// tb_synapse_receiver
//
// Scoreboard bench for synapse_receiver. The driver applies inputs on the
// falling edge and pushes the value a reference model predicts for the next
// rising edge; a monitor pops and compares just after every rising edge.
// Directed sequences with fixed expected currents are followed by a long
// randomized phase.
// -----------------------------------------------------------------------------
module tb_synapse_receiver;

  localparam int N            = 32;
  localparam int K            = 2;
  localparam int DECAY_SHIFT  = 4;
  localparam int DECAY_PERIOD = 4;
  localparam int MIN_WIDTH    = 3;
  localparam int RAND_CYCLES  = 3000;

  typedef struct {
    logic [N-1:0] i;
    logic [K-1:0] seen;
  } exp_t;

  logic clk;
  logic reset;

  synapse_receiver_if #(.N(N), .K(K)) bus ();

  synapse_receiver #(
    .N           (N),
    .K           (K),
    .DECAY_SHIFT (DECAY_SHIFT),
    .DECAY_PERIOD(DECAY_PERIOD),
    .MIN_WIDTH   (MIN_WIDTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, req, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: current as a plain integer, acceptance from the impulse
  // history of each line.
  // ---------------------------------------------------------------------------
  longint   m_i;
  int       m_phase;
  bit [K-1:0] m_level_before;
  int       m_run [K];

  function automatic longint decay_of(input longint cur);
    longint mag;
    mag = (cur < 0 ? -cur : cur) / (longint'(1) << DECAY_SHIFT);
    if (mag == 0 && cur != 0) mag = 1;
    return (cur < 0) ? -mag : mag;
  endfunction

  function automatic void model_step(input logic rst, input logic [K-1:0] syn,
                                     input logic [K*N-1:0] w);
    exp_t       e;
    logic [K-1:0] acc;
    longint     next;
    longint     lim_hi;
    longint     lim_lo;
    logic [N-1:0] wk;
    lim_hi = (longint'(1) << (N - 1)) - 1;
    lim_lo = -(longint'(1) << (N - 1));
    acc    = '0;
    if (rst) begin
      m_i            = 0;
      m_phase        = 0;
      m_level_before = '1;
      for (int k = 0; k < K; k++) m_run[k] = MIN_WIDTH;
    end else begin
      for (int k = 0; k < K; k++) begin
`ifdef SYNAPSE_GLITCH_FILTER_EN
        if (syn[k]) begin
          if (m_run[k] < MIN_WIDTH) begin
            m_run[k]++;
            acc[k] = (m_run[k] == MIN_WIDTH);
          end
        end else begin
          m_run[k] = 0;
        end
`else
        acc[k] = syn[k] && !m_level_before[k];
`endif
      end
      next = m_i;
      if (m_phase == DECAY_PERIOD - 1) next = next - decay_of(m_i);
      for (int k = 0; k < K; k++) begin
        wk = w[k*N +: N];
        if (acc[k]) next = next + longint'($signed(wk));
      end
      if (next > lim_hi) next = lim_hi;
      if (next < lim_lo) next = lim_lo;
      m_i            = next;
      m_phase        = (m_phase + 1) % DECAY_PERIOD;
      m_level_before = syn;
    end
    e.i    = m_i[N-1:0];
    e.seen = acc;
    exp_q.push_back(e);
  endfunction

  // ---------------------------------------------------------------------------
  // Driver helpers
  // ---------------------------------------------------------------------------
  task automatic drive(input logic rst, input logic [K-1:0] syn, input logic [K*N-1:0] w);
    @(negedge clk);
    reset      = rst;
    bus.synin  = syn;
    bus.weight = w;
    model_step(rst, syn, w);
  endtask

  // Fixed expectation for the value that appears after the coming edge.
  task automatic expect_dut(input string name, input logic [N-1:0] i_req,
                            input logic [K-1:0] seen_req);
    @(posedge clk);
    #2;
    check({name, "_I"}, 64'(bus.I), 64'(i_req));
    check({name, "_seen"}, 64'(bus.spike_seen), 64'(seen_req));
  endtask

  function automatic logic [K*N-1:0] w2(input logic [N-1:0] w0, input logic [N-1:0] w1);
    return {w1, w0};
  endfunction

  function automatic logic [N-1:0] rand_weight();
    logic [N-1:0] v;
    case ($urandom_range(0, 3))
      0: v = N'($urandom_range(0, 32'h0003_FFFF)) - N'(32'h0002_0000);
      1: v = N'($urandom);
      2: v = {4'h7, 28'($urandom)};
      default: v = {4'h8, 28'($urandom)};
    endcase
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("mon_I", 64'(bus.I), 64'(e.i));
        check("mon_seen", 64'(bus.spike_seen), 64'(e.seen));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "tb_synapse_receiver: simulation did not finish");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [N-1:0]   resid [6];
    logic [K-1:0]   lvl;
    logic [K*N-1:0] w;
    logic           rst;

    reset      = 1'b1;
    bus.synin  = '0;
    bus.weight = '0;
    resid = '{32'd4, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0};

    drive(1'b1, 2'b00, '0);
    drive(1'b1, 2'b00, '0);
    expect_dut("reset", '0, '0);

`ifndef SYNAPSE_GLITCH_FILTER_EN
    // Single 8-cycle impulse on input 0, rising when the decay phase is 1.
    drive(1'b0, 2'b00, w2(32'h0002_0000, '0));
    drive(1'b0, 2'b01, w2(32'h0002_0000, '0));
    expect_dut("single_rise", 32'h0002_0000, 2'b01);
    drive(1'b0, 2'b01, w2(32'h0002_0000, '0));
    expect_dut("single_hold", 32'h0002_0000, 2'b00);
    drive(1'b0, 2'b01, w2(32'h0002_0000, '0));
    expect_dut("decay_1", 32'h0001_E000, 2'b00);
    for (int c = 4; c <= 6; c++) begin
      drive(1'b0, 2'b01, w2(32'h0002_0000, '0));
      expect_dut("decay_flat", 32'h0001_E000, 2'b00);
    end
    drive(1'b0, 2'b01, w2(32'h0002_0000, '0));
    expect_dut("decay_2", 32'h0001_C200, 2'b00);
    drive(1'b0, 2'b01, w2(32'h0002_0000, '0));

    // Reset while the impulse is still high.
    drive(1'b1, 2'b01, w2(32'h0001_0000, '0));
    drive(1'b1, 2'b01, w2(32'h0001_0000, '0));
    expect_dut("midrst", '0, '0);
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 2'b01, w2(32'h0001_0000, '0));
      expect_dut("midrst_hold", '0, '0);
    end
    drive(1'b0, 2'b00, w2(32'h0001_0000, '0));
    drive(1'b0, 2'b01, w2(32'h0001_0000, '0));
    expect_dut("rearm", 32'h0001_0000, 2'b01);

    // Coincident spikes of opposite sign.
    drive(1'b1, 2'b00, '0);
    drive(1'b0, 2'b00, w2(32'h0003_0000, 32'hFFFF_0000));
    drive(1'b0, 2'b11, w2(32'h0003_0000, 32'hFFFF_0000));
    expect_dut("coincident", 32'h0002_0000, 2'b11);

    // Positive and negative saturation.
    drive(1'b1, 2'b00, '0);
    drive(1'b0, 2'b00, w2(32'h7000_0000, 32'h7000_0000));
    drive(1'b0, 2'b11, w2(32'h7000_0000, 32'h7000_0000));
    expect_dut("sat_pos", 32'h7FFF_FFFF, 2'b11);
    drive(1'b1, 2'b00, '0);
    drive(1'b0, 2'b00, w2(32'h9000_0000, 32'h9000_0000));
    drive(1'b0, 2'b11, w2(32'h9000_0000, 32'h9000_0000));
    expect_dut("sat_neg", 32'h8000_0000, 2'b11);

    // Residue: a current of 5 LSB decays by one LSB per event down to 0.
    drive(1'b1, 2'b00, '0);
    drive(1'b0, 2'b00, w2(32'd5, '0));
    drive(1'b0, 2'b01, w2(32'd5, '0));
    expect_dut("resid_load", 32'd5, 2'b01);
    for (int c = 2; c <= 23; c++) begin
      drive(1'b0, 2'b00, w2(32'd5, '0));
      if (c % 4 == 3) expect_dut("resid", resid[(c - 3) / 4], 2'b00);
    end
`else
    // Glitch filter: a 2-cycle pulse is dropped, a 3-cycle pulse lands.
    drive(1'b0, 2'b00, w2(32'h0001_0000, '0));
    drive(1'b0, 2'b01, w2(32'h0001_0000, '0));
    drive(1'b0, 2'b01, w2(32'h0001_0000, '0));
    drive(1'b0, 2'b00, w2(32'h0001_0000, '0));
    expect_dut("glitch_drop", '0, 2'b00);
    drive(1'b0, 2'b01, w2(32'h0001_0000, '0));
    drive(1'b0, 2'b01, w2(32'h0001_0000, '0));
    expect_dut("filter_wait", '0, 2'b00);
    drive(1'b0, 2'b01, w2(32'h0001_0000, '0));
    expect_dut("filter_accept", 32'h0001_0000, 2'b01);
    drive(1'b0, 2'b00, w2(32'h0001_0000, '0));
`endif

    // Randomized phase: held impulses of random length, random weights,
    // occasional resets landing anywhere in an impulse.
    lvl = '0;
    w   = '0;
    for (int c = 0; c < RAND_CYCLES; c++) begin
      rst = ($urandom_range(0, 79) == 0);
      for (int k = 0; k < K; k++) begin
        if ($urandom_range(0, 3) == 0) lvl[k] = ~lvl[k];
        if ($urandom_range(0, 2) == 0) w[k*N +: N] = rand_weight();
      end
      drive(rst, lvl, w);
    end

    drive(1'b0, '0, '0);
    @(posedge clk);
    #3;
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
